// File: rtl/move_left_ctrl.sv
// move_left_ctrl: reads the board cells bordering the piece's left edge and reports whether it can shift left.
// Build option MOVE_LEFT_PIPELINE_EN overlaps each read with the compare of the previous cell.
//
// state | meaning
// IDLE  | waiting for Request
// READ  | read strobe issued (pipelined build: read/compare streaming)
// CMP   | BoardData valid for the cell read last cycle
// DONE  | Done pulse, result registers updated
module move_left_ctrl #(
  parameter int         BOARD_ROWS = 20,
  parameter int         BOARD_COLS = 16,
  parameter logic [2:0] EMPTY_CODE = 3'b000
) (
  input  logic       Clock,
  input  logic       Resetn,
  input  logic       Request,
  input  logic [1:0] currentBlock,
  input  logic [3:0] XPOS,
  input  logic [4:0] YPOS,
  output logic [4:0] BoardRow,
  output logic [3:0] BoardCol,
  output logic       BoardRd,
  input  logic [2:0] BoardData,
  output logic       Busy,
  output logic       Done,
  output logic       canMove,
  output logic [3:0] NewXPOS
);

  typedef enum logic [1:0] {IDLE, READ, CMP, DONE} state_t;

  state_t     state;
  logic [1:0] blk_q;
  logic [3:0] xpos_q;
  logic [4:0] ypos_q;
  logic [1:0] idx;
  logic [1:0] nxt;
  logic       fin;
  logic       fin_ok;
  logic [3:0] fin_x;
`ifdef MOVE_LEFT_PIPELINE_EN
  logic       cmp_pend;
  logic [1:0] cmp_idx;
`endif

  assign nxt = idx + 2'd1;

  function automatic logic [1:0] row_off(input logic [1:0] blk, input logic [1:0] k);
    case (blk)
      2'b10:   row_off = (k == 2'd0) ? 2'd2 : 2'd3;
      2'b11:   row_off = 2'd3;
      default: row_off = k + 2'd1;
    endcase
  endfunction

  function automatic int col_delta(input logic [1:0] blk, input logic [1:0] k);
    if (blk == 2'b11) return -1;
    else if (blk == 2'b01 && k == 2'd2) return 1;
    else return 0;
  endfunction

  function automatic logic [1:0] last_idx(input logic [1:0] blk);
    case (blk)
      2'b10:   last_idx = 2'd1;
      2'b11:   last_idx = 2'd0;
      default: last_idx = 2'd2;
    endcase
  endfunction

  // Cells below the bottom row count as occupied and are never read.
  function automatic logic off_board(input logic [4:0] ypos, input logic [3:0] xpos,
                                     input logic [1:0] blk, input logic [1:0] k);
    int r;
    int c;
    r = int'(ypos) + int'(row_off(blk, k));
    c = int'(xpos) + col_delta(blk, k);
    return (r > BOARD_ROWS - 1) || (c < 0) || (c > BOARD_COLS - 1);
  endfunction

  always_comb begin
    fin    = 1'b0;
    fin_ok = 1'b0;
    fin_x  = xpos_q;
    case (state)
      IDLE: begin
        fin_x = XPOS;
        if (Request && (XPOS == 4'd0 || off_board(YPOS, XPOS, currentBlock, 2'd0))) fin = 1'b1;
      end
`ifdef MOVE_LEFT_PIPELINE_EN
      READ: begin
        if (cmp_pend && BoardData != EMPTY_CODE) fin = 1'b1;
        else if (cmp_pend && cmp_idx == last_idx(blk_q)) begin
          fin    = 1'b1;
          fin_ok = 1'b1;
        end else if (BoardRd && idx != last_idx(blk_q) && off_board(ypos_q, xpos_q, blk_q, nxt))
          fin = 1'b1;
      end
`else
      CMP: begin
        if (BoardData != EMPTY_CODE) fin = 1'b1;
        else if (idx == last_idx(blk_q)) begin
          fin    = 1'b1;
          fin_ok = 1'b1;
        end else if (off_board(ypos_q, xpos_q, blk_q, nxt)) fin = 1'b1;
      end
`endif
      default: ;
    endcase
  end

  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      state    <= IDLE;
      Busy     <= 1'b0;
      Done     <= 1'b0;
      canMove  <= 1'b0;
      NewXPOS  <= 4'd0;
      BoardRd  <= 1'b0;
      BoardRow <= 5'd0;
      BoardCol <= 4'd0;
      idx      <= 2'd0;
      blk_q    <= 2'd0;
      xpos_q   <= 4'd0;
      ypos_q   <= 5'd0;
`ifdef MOVE_LEFT_PIPELINE_EN
      cmp_pend <= 1'b0;
      cmp_idx  <= 2'd0;
`endif
    end else begin
      Done <= 1'b0;
      case (state)
        IDLE: if (Request) begin
          blk_q    <= currentBlock;
          xpos_q   <= XPOS;
          ypos_q   <= YPOS;
          idx      <= 2'd0;
          Busy     <= 1'b1;
          BoardRd  <= 1'b1;
          BoardRow <= YPOS + {3'b000, row_off(currentBlock, 2'd0)};
          BoardCol <= XPOS + 4'(col_delta(currentBlock, 2'd0));
          state    <= READ;
`ifdef MOVE_LEFT_PIPELINE_EN
          cmp_pend <= 1'b0;
`endif
        end
`ifdef MOVE_LEFT_PIPELINE_EN
        READ: begin
          cmp_pend <= BoardRd;
          cmp_idx  <= idx;
          if (BoardRd && idx != last_idx(blk_q)) begin
            idx      <= nxt;
            BoardRow <= ypos_q + {3'b000, row_off(blk_q, nxt)};
            BoardCol <= xpos_q + 4'(col_delta(blk_q, nxt));
          end else begin
            BoardRd <= 1'b0;
          end
        end
`else
        READ: begin
          BoardRd <= 1'b0;
          state   <= CMP;
        end
        CMP: begin
          idx      <= nxt;
          BoardRd  <= 1'b1;
          BoardRow <= ypos_q + {3'b000, row_off(blk_q, nxt)};
          BoardCol <= xpos_q + 4'(col_delta(blk_q, nxt));
          state    <= READ;
        end
`endif
        DONE: begin
          Busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
      // Finishing overrides whatever progress the state branch scheduled.
      if (fin) begin
        state   <= DONE;
        Done    <= 1'b1;
        BoardRd <= 1'b0;
        canMove <= fin_ok;
        NewXPOS <= fin_ok ? fin_x - 4'd1 : fin_x;
      end
    end
  end

endmodule

// File: tb/tb_move_left_ctrl.sv
// Bench for move_left_ctrl: board memory model, cycle-level expectation model and per-cycle compare.
module tb_move_left_ctrl;

`ifdef MOVE_LEFT_PIPELINE_EN
  localparam bit PIPE = 1'b1;
`else
  localparam bit PIPE = 1'b0;
`endif

  logic       Clock = 1'b0;
  logic       Resetn = 1'b0;
  logic       Request = 1'b0;
  logic [1:0] currentBlock = 2'd0;
  logic [3:0] XPOS = 4'd0;
  logic [4:0] YPOS = 5'd0;
  logic [4:0] BoardRow;
  logic [3:0] BoardCol;
  logic       BoardRd;
  logic [2:0] BoardData = 3'd0;
  logic       Busy, Done, canMove;
  logic [3:0] NewXPOS;

  always #5 Clock = ~Clock;

  move_left_ctrl dut (
    .Clock(Clock), .Resetn(Resetn), .Request(Request), .currentBlock(currentBlock),
    .XPOS(XPOS), .YPOS(YPOS), .BoardRow(BoardRow), .BoardCol(BoardCol), .BoardRd(BoardRd),
    .BoardData(BoardData), .Busy(Busy), .Done(Done), .canMove(canMove), .NewXPOS(NewXPOS)
  );

  logic [2:0] board [0:19][0:15];
  always @(posedge Clock) if (BoardRd && BoardRow < 5'd20) BoardData <= board[BoardRow][BoardCol];

  int cyc = 0;
  always @(posedge Clock) cyc <= cyc + 1;

  int tests = 0;
  int fails = 0;

  // Left-border cells per piece: J2, S2, O, I1.
  int roff [4][3] = '{'{1, 2, 3}, '{1, 2, 3}, '{2, 3, 0}, '{3, 0, 0}};
  int coff [4][3] = '{'{0, 0, 0}, '{0, 0, 1}, '{0, 0, 0}, '{-1, 0, 0}};
  int ncell [4]   = '{3, 3, 2, 1};

  bit         chk_en = 1'b0;
  bit         txn_active = 1'b0;
  int         c0 = 0;
  int         exp_done = 0;
  bit         exp_can = 1'b0;
  int         exp_newx = 0;
  bit         exp_rd [0:15];
  int         exp_row [0:15];
  int         exp_col [0:15];
  bit         held_can = 1'b0;
  int         held_newx = 0;
  int         rd_seen = 0;

  task automatic check(input string name, input int act, input int req);
    tests++;
    if (act != req) begin
      fails++;
      $display("FAIL %s at cyc %0d: got %0d, expected %0d", name, cyc, act, req);
    end
  endtask

  task automatic clear_board();
    for (int r = 0; r < 20; r++)
      for (int c = 0; c < 16; c++) board[r][c] = 3'd0;
  endtask

  // Outcome from the first blocking event: a stop at a cell bounds Done, reads are the cells whose read slot precedes Done.
  task automatic build_model(input int blk, input int x, input int y);
    int n, occ_k, oor_m, t, r, c, rc;
    n = ncell[blk];
    occ_k = -1;
    oor_m = -1;
    for (int j = 0; j < 16; j++) exp_rd[j] = 1'b0;
    exp_done = PIPE ? n + 2 : 2 * n + 1;
    exp_can = 1'b1;
    if (x == 0) begin
      exp_done = 1;
      exp_can = 1'b0;
    end else begin
      for (int j = 0; j < n; j++) begin
        r = y + roff[blk][j];
        c = x + coff[blk][j];
        if (oor_m < 0 && r > 19) oor_m = j;
        if (oor_m < 0 && occ_k < 0 && r <= 19 && board[r][c] != 3'd0) occ_k = j;
      end
      if (occ_k >= 0) begin
        t = PIPE ? occ_k + 3 : 2 * occ_k + 3;
        if (t < exp_done) exp_done = t;
        exp_can = 1'b0;
      end
      if (oor_m >= 0) begin
        t = PIPE ? oor_m + 1 : 2 * oor_m + 1;
        if (t < exp_done) exp_done = t;
        exp_can = 1'b0;
      end
      for (int j = 0; j < n; j++) begin
        rc = PIPE ? j + 1 : 2 * j + 1;
        if (rc < exp_done) begin
          exp_rd[rc] = 1'b1;
          exp_row[rc] = y + roff[blk][j];
          exp_col[rc] = x + coff[blk][j];
        end
      end
    end
    exp_newx = exp_can ? x - 1 : x;
  endtask

  always @(negedge Clock) begin
    int t;
    if (chk_en) begin
      if (txn_active && cyc >= c0 && cyc <= c0 + exp_done) begin
        t = cyc - c0;
        check("rd_strobe", int'(BoardRd), int'(exp_rd[t]));
        if (exp_rd[t]) begin
          check("rd_row", int'(BoardRow), exp_row[t]);
          check("rd_col", int'(BoardCol), exp_col[t]);
        end
        if (BoardRd) rd_seen++;
        check("done", int'(Done), int'(t == exp_done));
        check("busy", int'(Busy), int'(t >= 1));
        if (t == exp_done) begin
          check("canmove", int'(canMove), int'(exp_can));
          check("newxpos", int'(NewXPOS), exp_newx);
          held_can = exp_can;
          held_newx = exp_newx;
        end else begin
          check("canmove_held", int'(canMove), int'(held_can));
          check("newxpos_held", int'(NewXPOS), held_newx);
        end
      end else begin
        check("idle_done", int'(Done), 0);
        check("idle_busy", int'(Busy), 0);
        check("idle_rd", int'(BoardRd), 0);
        check("idle_canmove", int'(canMove), int'(held_can));
        check("idle_newxpos", int'(NewXPOS), held_newx);
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge Clock);
      #2;
    end
  endtask

  // Called at posedge+2; returns at posedge+2 of the first IDLE cycle after Done.
  task automatic run_txn(input int blk, input int x, input int y, input bit hold,
                         input int lit_done, input int lit_can, input int lit_newx, input int lit_reads);
    build_model(blk, x, y);
    check("model_done", exp_done, lit_done);
    check("model_can", int'(exp_can), lit_can);
    check("model_newx", exp_newx, lit_newx);
    c0 = cyc;
    rd_seen = 0;
    txn_active = 1'b1;
    currentBlock = 2'(blk);
    XPOS = 4'(x);
    YPOS = 5'(y);
    Request = 1'b1;
    @(posedge Clock);
    #2;
    if (hold) begin
      XPOS = 4'd0;
      YPOS = 5'd31;
      currentBlock = 2'd3;
    end else begin
      Request = 1'b0;
    end
    while (cyc < c0 + exp_done + 1) begin
      @(posedge Clock);
      #2;
    end
    check("read_count", rd_seen, lit_reads);
  endtask

  initial begin
    clear_board();
    @(posedge Clock);
    #2;
    check("reset_outs", int'({Busy, Done, canMove, NewXPOS, BoardRd, BoardRow, BoardCol}), 0);
    Resetn = 1'b1;
    chk_en = 1'b1;
    idle(1);

    run_txn(2, 5, 10, 1'b0, PIPE ? 4 : 5, 1, 4, 2);
    idle(1);
    board[19][0] = 3'b010;
    run_txn(3, 1, 16, 1'b0, 3, 0, 1, 1);
    board[19][0] = 3'b000;
    run_txn(0, 0, 5, 1'b0, 1, 0, 0, 0);
    idle(2);
    board[3][7] = 3'b101;
    run_txn(1, 7, 2, 1'b0, 3, 0, 7, PIPE ? 2 : 1);
    board[3][7] = 3'b000;
    run_txn(0, 3, 17, 1'b0, PIPE ? 3 : 5, 0, 3, 2);
    run_txn(1, 7, 2, 1'b0, PIPE ? 5 : 7, 1, 6, 3);
    idle(1);
    board[3][10] = 3'b001;
    run_txn(0, 10, 0, 1'b1, PIPE ? 5 : 7, 0, 10, 3);
    board[3][10] = 3'b000;
    run_txn(3, 15, 0, 1'b0, 3, 1, 14, 1);
    run_txn(2, 4, 18, 1'b0, 1, 0, 4, 0);
    idle(1);
    run_txn(3, 15, 0, 1'b0, 3, 1, 14, 1);
    idle(1);

    // Abort in the compare cycle of a J2 check.
    chk_en = 1'b0;
    txn_active = 1'b0;
    currentBlock = 2'd0;
    XPOS = 4'd5;
    YPOS = 5'd2;
    Request = 1'b1;
    @(posedge Clock);
    #2;
    Request = 1'b0;
    @(posedge Clock);
    #2;
    check("pre_reset_busy", int'(Busy), 1);
    check("pre_reset_rd", int'(BoardRd), int'(PIPE));
    Resetn = 1'b0;
    #1;
    check("abort_outs", int'({Busy, Done, canMove, NewXPOS, BoardRd, BoardRow, BoardCol}), 0);
    @(negedge Clock);
    check("abort_no_done", int'(Done), 0);
    @(posedge Clock);
    #2;
    check("abort_no_done2", int'(Done), 0);
    Resetn = 1'b1;
    held_can = 1'b0;
    held_newx = 0;
    chk_en = 1'b1;
    idle(2);
    run_txn(2, 5, 10, 1'b0, PIPE ? 4 : 5, 1, 4, 2);
    idle(2);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/move_left_ctrl.md
Name: move_left_ctrl

Overview:
- Sequential left-move checker and executor for the falling piece.
- On a request it reads only the board cells that border the piece's left edge, one at a time, through a registered board read port; it does not take the whole board array as input.
- If every bordering cell is empty and in range, it returns the decremented X position.
- Sits between the input/game FSM (which issues Request) and the board memory (which serves reads); it is the left-hand counterpart of the right-move check.

Parameters:
- BOARD_ROWS, 20, number of board rows; valid rows are 0..BOARD_ROWS-1.
- BOARD_COLS, 16, number of board columns.
- EMPTY_CODE, 3'b000, cell code meaning "free".

Ports:
- Clock  in  1  system clock, rising edge.
- Resetn  in  1  asynchronous, active-low reset.
- Request  in  1  start a left-move check; sampled only in IDLE.
- currentBlock  in  2  piece code: 00 J2, 01 S2, 10 O, 11 I1.
- XPOS  in  4  column of the 4x4 bounding box origin.
- YPOS  in  5  row of the 4x4 bounding box origin.
- BoardRow  out  5  read row address.
- BoardCol  out  4  read column address.
- BoardRd  out  1  read strobe.
- BoardData  in  3  cell code, valid exactly 1 cycle after BoardRd.
- Busy  out  1  high from the cycle after an accepted Request through the DONE cycle.
- Done  out  1  one-cycle pulse; result valid.
- canMove  out  1  result; held until the next Done.
- NewXPOS  out  4  XPOS-1 if canMove, else latched XPOS; held until the next Done.

Behaviour:
- Reset (async, Resetn=0) values: state IDLE, Busy=0, Done=0, canMove=0, NewXPOS=0, BoardRd=0, BoardRow=0, BoardCol=0, cell index=0.
- Accept: in IDLE, Request=1 latches currentBlock, XPOS and YPOS. Request while Busy is ignored.
- Left-border cell lists (row offset, column offset relative to XPOS), checked in the order given:
  - J2: (1,0), (2,0), (3,0)
  - S2: (1,0), (2,0), (3,1)
  - O: (2,0), (3,0)
  - I1: (3,-1)
- Checks made before any read:
  - Latched XPOS==0: go straight to DONE with canMove=0 and no reads.
  - I1 with XPOS==1 is legal: its checked column is 0.
- Row range: a cell with YPOS+row > BOARD_ROWS-1 counts as occupied. No read is issued for it; the FSM goes to DONE with canMove=0.
- FSM:
  - IDLE -> READ on an accepted Request.
  - READ: BoardRd=1, BoardRow=YPOS+r, BoardCol=XPOS+c (4-bit, no wrap is possible after the prechecks). Next state CMP.
  - CMP: sample BoardData.
    - BoardData != EMPTY_CODE -> DONE with canMove=0.
    - Last cell -> DONE with canMove=1.
    - Otherwise increment the index and go to READ.
  - DONE: Done=1 for one cycle; update canMove and NewXPOS; Busy=1; next state IDLE.
- Latency (Request sampled at cycle 0, all cells free): Done at cycle 2N+1, where N is the number of cells. O gives cycle 5; J2/S2 give cycle 7; I1 gives cycle 3.
- Early exit: on the first occupied cell; no further reads are issued.
- A Request in the DONE cycle is ignored; a Request in the following IDLE cycle is accepted.
- Reset mid-operation aborts immediately to reset values; no Done pulse is produced.

Optional Feature:
- Macro: MOVE_LEFT_PIPELINE_EN.
- Defined:
  - One read is issued per cycle; cell k is compared in the cycle in which cell k+1 is read.
  - Done arrives at cycle N+2 (O: 4, J2: 5, I1: 3).
  - On an occupied cell, any read issued in the same cycle is discarded; Done comes the next cycle.
- Undefined: the 2-cycle READ/CMP sequence described above.
- Ports, results and the XPOS==0 / row-range prechecks are identical in both builds.

Test Plan:
- O, XPOS=5, YPOS=10, board empty -> reads (12,5) then (13,5); Done at cycle 5 (pipelined: 4); canMove=1; NewXPOS=4.
- I1, XPOS=1, YPOS=16, cell (19,0)=3'b010 -> one read at (19,0); canMove=0; NewXPOS=1.
- J2, XPOS=0 -> no BoardRd; Done at cycle 1; canMove=0; NewXPOS=0.
- S2, XPOS=7, YPOS=2, cell (3,7) occupied -> reads (3,7) only; early Done; canMove=0.
- J2, YPOS=17 -> row 20 is out of range; canMove=0 after the reads of rows 18 and 19.
- Resetn pulled low during CMP -> all outputs return to reset values; no Done pulse; a new Request after reset completes normally.
